// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared status codes, BCD record and 7-segment decode for the stopwatch display
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUNNING = 2'b01;
  localparam logic [1:0] ST_PAUSED  = 2'b10;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
  } bcd_time_t;

  typedef enum logic [1:0] {
    CV_IDLE,
    CV_RUN,
    CV_DONE
  } conv_state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/stopwatch_display_if.sv
// rtl/stopwatch_display_if.sv - time inputs and multiplexed 7-segment outputs of the stopwatch display
interface stopwatch_display_if;

  logic [7:0] minutes;
  logic [5:0] seconds;
  logic [1:0] status;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       min_ovf;

  modport master (
    output minutes, seconds, status,
    input  an, seg, dp, min_ovf
  );

  modport slave (
    input  minutes, seconds, status,
    output an, seg, dp, min_ovf
  );

endinterface

// File: rtl/bcd_converter.sv
// rtl/bcd_converter.sv - sequential double-dabble of minutes and seconds, one add-3/shift per cycle
module bcd_converter
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] minutes,
  input  logic [5:0] seconds,
  output logic       busy,
  output logic       done,
  output bcd_time_t  result,
  output logic [3:0] min_hund
);

  conv_state_t state, state_nx;
  logic [7:0]  bin_m;
  logic [7:0]  bin_s;
  logic [11:0] bcd_m;
  logic [7:0]  bcd_s;
  logic [2:0]  iter;
  logic        load;
  logic        step;
  logic [19:0] m_shift;
  logic [15:0] s_shift;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  always_comb begin
    m_shift = {add3(bcd_m[11:8]), add3(bcd_m[7:4]), add3(bcd_m[3:0]), bin_m} << 1;
    s_shift = {add3(bcd_s[7:4]), add3(bcd_s[3:0]), bin_s} << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CV_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // DONE is a one-cycle hold so the result is stable while the top commits it
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    done     = 1'b0;
    busy     = (state != CV_IDLE);
    case (state)
      CV_IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = CV_RUN;
        end
      end
      CV_RUN: begin
        step = 1'b1;
        if (iter == 3'd7) begin
          state_nx = CV_DONE;
        end
      end
      CV_DONE: begin
        done     = 1'b1;
        state_nx = CV_IDLE;
      end
      default: state_nx = CV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_m <= '0;
      bin_s <= '0;
      bcd_m <= '0;
      bcd_s <= '0;
      iter  <= '0;
    end else if (load) begin
      bin_m <= minutes;
      bin_s <= {2'b00, seconds};
      bcd_m <= '0;
      bcd_s <= '0;
      iter  <= '0;
    end else if (step) begin
      {bcd_m, bin_m} <= m_shift;
      {bcd_s, bin_s} <= s_shift;
      iter           <= iter + 3'd1;
    end
  end

  assign result   = {bcd_m[7:4], bcd_m[3:0], bcd_s[7:4], bcd_s[3:0]};
  assign min_hund = bcd_m[11:8];

endmodule

// File: rtl/stopwatch_display.sv
// rtl/stopwatch_display.sv - MM:SS multiplexed common-anode display with blink while paused
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_TICKS = 250
) (
  input logic                clk,
  input logic                rst,
  stopwatch_display_if.slave bus
);

  localparam int RC_W = $clog2(REFRESH_DIV);
  localparam int BC_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [7:0]      snap_min;
  logic [5:0]      snap_sec;
  logic            start;
  logic            conv_busy;
  logic            conv_done;
  bcd_time_t       conv_result;
  logic [3:0]      conv_hund;
  bcd_time_t       disp;
  bcd_time_t       view;
  logic            ovf_r;
  logic [RC_W-1:0] rc;
  logic            tick;
  logic [1:0]      idx;
  logic [3:0]      digit;
  logic [BC_W-1:0] bcnt;
  logic            phase_on;
  logic            paused;
  logic            show;
  logic [3:0]      an_r;
  logic [6:0]      seg_r;
  logic            dp_r;

  assign start = !conv_busy && ({bus.minutes, bus.seconds} != {snap_min, snap_sec});

  bcd_converter u_conv (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .minutes  (bus.minutes),
    .seconds  (bus.seconds),
    .busy     (conv_busy),
    .done     (conv_done),
    .result   (conv_result),
    .min_hund (conv_hund)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_min <= '0;
      snap_sec <= '0;
    end else if (start) begin
      snap_min <= bus.minutes;
      snap_sec <= bus.seconds;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp  <= '0;
      ovf_r <= 1'b0;
    end else if (conv_done) begin
      disp  <= conv_result;
      ovf_r <= (conv_hund != 4'd0);
    end
  end

  // Forward a commit landing on a scan tick so the new digit shows in that update
  assign view   = conv_done ? conv_result : disp;
  assign tick   = (rc == RC_W'(REFRESH_DIV - 1));
  assign paused = (bus.status == ST_PAUSED);
  assign show   = !paused || phase_on;

  always_comb begin
    digit = view.sec_units;
    case (idx)
      2'd1:    digit = view.sec_tens;
      2'd2:    digit = view.min_units;
      2'd3:    digit = view.min_tens;
      default: digit = view.sec_units;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rc    <= '0;
      idx   <= '0;
      an_r  <= 4'b1111;
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
    end else if (tick) begin
      rc    <= '0;
      idx   <= idx + 2'd1;
      an_r  <= ~(4'b0001 << idx);
      seg_r <= show ? seg_decode(digit) : SEG_BLANK;
      dp_r  <= !(show && (idx == 2'd2));
    end else begin
      rc <= rc + RC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !paused) begin
      bcnt     <= '0;
      phase_on <= 1'b1;
    end else if (tick) begin
      if (bcnt == BC_W'(BLINK_TICKS - 1)) begin
        bcnt     <= '0;
        phase_on <= !phase_on;
      end else begin
        bcnt <= bcnt + BC_W'(1);
      end
    end
  end

  assign bus.an      = an_r;
  assign bus.seg     = seg_r;
  assign bus.dp      = dp_r;
  assign bus.min_ovf = ovf_r;

endmodule

// File: tb/tb_stopwatch_display.sv
// tb/tb_stopwatch_display.sv - randomized scoreboard bench for stopwatch_display
module tb_stopwatch_display;

  localparam int DIV = 4;
  localparam int BT  = 2;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stopwatch_display_if bus();

  stopwatch_display #(.REFRESH_DIV(DIV), .BLINK_TICKS(BT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  ev_t sbq[$];
  int  n_chk = 0;
  int  n_err = 0;
  int  cyc = 0;
  bit  rst_edge = 1'b0;
  int  e_ovf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: timing rules as plain arithmetic on edge counts
  initial begin
    int snap_m, snap_s, dm, ds, since, pticks, commit_cyc, k, digit;
    bit m_busy, start, paused, on;
    logic [3:0] nx_an, pv_an;
    logic [6:0] nx_seg, pv_seg;
    logic       nx_dp, pv_dp;
    snap_m = 0; snap_s = 0; dm = 0; ds = 0; since = 0; pticks = 0; commit_cyc = 0; m_busy = 0;
    nx_an = 4'hF; nx_seg = 7'h7F; nx_dp = 1'b1;
    pv_an = 4'hF; pv_seg = 7'h7F; pv_dp = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      rst_edge = rst;
      if (rst) begin
        snap_m = 0; snap_s = 0; m_busy = 0; dm = 0; ds = 0; e_ovf = 0;
        since = 0; pticks = 0;
        nx_an = 4'hF; nx_seg = 7'h7F; nx_dp = 1'b1;
      end else begin
        start = !m_busy && (int'(bus.minutes) != snap_m || int'(bus.seconds) != snap_s);
        if (m_busy && cyc == commit_cyc) begin
          dm = snap_m; ds = snap_s; e_ovf = (snap_m > 99) ? 1 : 0; m_busy = 0;
        end
        if (start) begin
          snap_m = int'(bus.minutes); snap_s = int'(bus.seconds);
          m_busy = 1; commit_cyc = cyc + 9;
        end
        paused = (bus.status == 2'b10);
        if (since % DIV == DIV - 1) begin
          k  = (since / DIV) % 4;
          on = !paused || ((pticks / BT) % 2 == 0);
          case (k)
            0:       digit = ds % 10;
            1:       digit = ds / 10;
            2:       digit = (dm % 100) % 10;
            default: digit = (dm % 100) / 10;
          endcase
          nx_an  = an_tab[k];
          nx_seg = on ? pat[digit] : 7'h7F;
          nx_dp  = !(on && k == 2);
          if (paused) pticks++;
        end
        if (!paused) pticks = 0;
        since++;
      end
      if (nx_an != pv_an || nx_seg != pv_seg || nx_dp != pv_dp) begin
        sbq.push_back('{cyc, nx_an, nx_seg, nx_dp});
        pv_an = nx_an; pv_seg = nx_seg; pv_dp = nx_dp;
      end
    end
  end

  // Monitor: every change on an/seg/dp pops one expected update
  initial begin
    logic [3:0] pa;
    logic [6:0] ps;
    logic       pd;
    ev_t        e;
    pa = 4'hF; ps = 7'h7F; pd = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_edge) begin
        chk("reset_an", 32'(bus.an), 32'hF);
        chk("reset_seg", 32'(bus.seg), 32'h7F);
        chk("reset_dp", 32'(bus.dp), 32'h1);
      end
      chk("min_ovf", 32'(bus.min_ovf), 32'(e_ovf));
      if (bus.an !== pa || bus.seg !== ps || bus.dp !== pd) begin
        if (sbq.size() == 0) begin
          chk("unexpected_update", 32'(bus.an), 32'hF);
        end else begin
          e = sbq.pop_front();
          chk("update_cycle", 32'(cyc), 32'(e.cyc));
          chk("an", 32'(bus.an), 32'(e.an));
          chk("seg", 32'(bus.seg), 32'(e.seg));
          chk("dp", 32'(bus.dp), 32'(e.dp));
        end
        pa = bus.an; ps = bus.seg; pd = bus.dp;
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply(input int m, input int s, input logic [1:0] st);
    bus.minutes = 8'(m);
    bus.seconds = 6'(s);
    bus.status  = st;
  endtask

  initial begin
    apply(0, 0, 2'b00);
    rst = 1'b1;
    hold(2);
    rst = 1'b0;
    hold(40);
    apply(12, 34, 2'b00);  hold(40);
    apply(123, 59, 2'b01); hold(40);
    apply(7, 59, 2'b01);   hold(40);
    apply(7, 5, 2'b01);    hold(3);
    bus.seconds = 6'd6;    hold(40);
    bus.status = 2'b10;    hold(46);
    bus.status = 2'b01;    hold(30);
    apply(45, 17, 2'b00);  hold(4);
    rst = 1'b1;            hold(1);
    rst = 1'b0;            hold(40);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.seconds = 6'($urandom_range(0, 63));
      end else begin
        apply(int'($urandom_range(0, 255)), int'($urandom_range(0, 63)), 2'($urandom_range(0, 3)));
      end
      hold(int'($urandom_range(1, 25)));
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        hold(int'($urandom_range(1, 2)));
        rst = 1'b0;
      end
    end
    bus.status = 2'b10; hold(40);
    bus.status = 2'b00; hold(40);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
- Downstream stage of the stopwatch top. Consumes minutes[7:0], seconds[5:0] and status[1:0], and drives a 4-digit multiplexed common-anode 7-segment display as MM:SS.
- Binary-to-BCD conversion is sequential (double-dabble). Digits are time-multiplexed at a refresh rate derived from clk.
- Display blinks while PAUSED.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot (scan tick period); must be >= 2.
- BLINK_TICKS, 250, scan ticks per blink half-period in PAUSED.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- minutes  in  8  binary minutes, 0..255.
- seconds  in  6  binary seconds, 0..59 (60..63 displayed as computed, no checking).
- status  in  2  00=IDLE, 01=RUNNING, 10=PAUSED, 11 treated as IDLE.
- an  out  4  digit anodes, active-low, one-hot-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; used as the MM:SS colon.
- min_ovf  out  1  high while the displayed snapshot has minutes > 99.

Behaviour:
- Reset (rst=1 at a clk edge) clears all state:
  - Outputs: an=4'b1111, seg=7'h7F, dp=1, min_ovf=0.
  - Internal: digit index 0, refresh counter 0, blink counter 0, blink phase ON, snapshot 0, BCD display regs 0, converter idle.
- Reset applied mid-conversion aborts the conversion. No partial result is ever displayed.

Conversion:
- Trigger: at any edge where the converter is idle and {minutes,seconds} != snapshot, latch snapshot <= inputs and start.
- Algorithm: minutes (8 b -> hundreds/tens/units) and zero-extended seconds (8 b -> tens/units) use 8 add-3/shift iterations in parallel, one iteration per cycle.
- Commit: on the 8th iteration the display BCD regs update atomically (min_tens, min_units, sec_tens, sec_units, min_ovf = hundreds != 0). The converter returns to idle on the following cycle.
- Latency: display regs hold the new value exactly 9 edges after the sampling edge.
- Inputs changing while busy are ignored until idle, then re-compared. The last stable value is always displayed within 19 cycles.
- Minutes > 99: show minutes mod 100 (tens/units digits) and assert min_ovf.

Scan:
- Refresh counter counts 0..REFRESH_DIV-1 and wraps. The wrap cycle is a scan tick.
- Digit index advances 0->1->2->3->0 on each tick.
- Mapping:
  - idx0 = sec_units.
  - idx1 = sec_tens.
  - idx2 = min_units, dp=0 (colon); dp=1 on all other digits.
  - idx3 = min_tens.
- an = ~(4'b0001 << idx). an/seg/dp are registered and reflect the new idx one cycle after the tick.
- No leading-zero blanking: 0 shows as "00:00". Decode 0..9 to standard patterns; codes 10..15 (unreachable) show all-off.

Blink:
- The blink counter counts scan ticks only while status==PAUSED. It toggles the blink phase at BLINK_TICKS-1 and wraps to 0.
- Leaving PAUSED clears the blink counter and forces phase ON.
- PAUSED with phase OFF: seg=7'h7F and dp=1 while an keeps scanning.
- IDLE and RUNNING always show phase ON.

Simultaneous events:
- Tick coincident with conversion commit: the new digit value is displayed in that same registered update.
- Status change coincident with a tick: the new status governs that update.

Decomposition:
- Shared package stopwatch_pkg holds:
  - status encodings ST_IDLE=2'b00, ST_RUNNING=2'b01, ST_PAUSED=2'b10;
  - the 7-segment pattern constants for 0..9 and SEG_BLANK;
  - the decode function.
- Sub-module bcd_converter: sequential double-dabble with start, busy and done, plus BCD outputs. Instantiated once.
- Scan, blink and output registers live in stopwatch_display.

Test Plan:
- Reset: rst high 2 cycles, then low, inputs 0 -> an=1111, seg=7F, dp=1 during reset; after the first tick (REFRESH_DIV=4 in bench) an cycles 1110,1101,1011,0111 with seg=pattern "0" and dp=0 only when an=1011.
- Conversion: minutes=12, seconds=34 applied at edge N -> BCD regs read 1,2,3,4 at edge N+9 and not earlier; scanned seg matches "4","3","2"(dp=0),"1".
- Overflow: minutes=123, seconds=59 -> digits "23:59", min_ovf=1; then minutes=7 -> "07:59", min_ovf=0.
- Back-to-back change: seconds 5 -> 6 at edge N+3 during busy -> "5" commits at N+9, "6" commits by N+19; no other value ever appears.
- Blink: status=PAUSED, BLINK_TICKS=2 -> seg goes 7F/dp=1 for 2 ticks and shows digits for 2 ticks alternately; switching to RUNNING mid-OFF restores digits on the next registered update.
- Reset mid-conversion: rst pulsed at busy cycle 4 -> BCD regs 0 and an=1111 during reset; unchanged inputs then retrigger conversion and commit 9 edges after the next sampling edge.
